// File: rtl/fpmul_arb_pkg.sv
// Shared constants and types for the FPmul arbiter.
// The optional FPMUL_ARB_PERF_EN build uses PERF_CNT_W.
package fpmul_arb_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned PERF_CNT_W  = 16;
    localparam int unsigned TAG_ID_W    = 3;

    // Index width for a requester count, never narrower than one bit.
    function automatic int unsigned tag_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/fpmul_arb_rr.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, with wrap-around.
module fpmul_arb_rr
    import fpmul_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned TAG_W = tag_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [TAG_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [TAG_W-1:0] grant_idx,
    output logic             grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Upper part of the ring first, then the wrapped lower part.
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!grant_any && req_valid[i] && (i >= int'(rr_ptr))) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = TAG_W'(i);
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!grant_any && req_valid[i] && (i < int'(rr_ptr))) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = TAG_W'(i);
            end
        end
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one fixed-latency pipelined FPmul between N_REQ requesters; a tag pipe routes results back.
// Define FPMUL_ARB_PERF_EN to add saturating per-requester issue and global stall counters.
module fpmul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned FP_W    = fpmul_arb_pkg::FP_W,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*FP_W-1:0] req_a,
    input  logic [N_REQ*FP_W-1:0] req_b,
    output logic [FP_W-1:0]       mul_a,
    output logic [FP_W-1:0]       mul_b,
    input  logic [FP_W-1:0]       mul_z,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_data,
    output logic                  busy
`ifdef FPMUL_ARB_PERF_EN
    ,
    output logic [N_REQ*PERF_CNT_W-1:0] perf_issue_cnt,
    output logic [PERF_CNT_W-1:0]       perf_stall_cnt
`endif
);

    localparam int unsigned TAG_W = tag_w(N_REQ);

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] grant;
    logic [TAG_W-1:0] grant_idx;
    logic             grant_any;
    tag_t             tag_q [MUL_LAT+1];
    tag_t             tag_exit;

    fpmul_arb_rr #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign tag_exit  = tag_q[MUL_LAT];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (int'(grant_idx) == int'(N_REQ) - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= int'(MUL_LAT); i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int i = 0; i <= int'(MUL_LAT); i++) begin
                tag_q[i] <= TAG_IDLE;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (grant_any) begin
                mul_a <= req_a[int'(grant_idx)*FP_W +: FP_W];
                mul_b <= req_b[int'(grant_idx)*FP_W +: FP_W];
            end
            tag_q[0] <= '{valid: grant_any, id: TAG_ID_W'(grant_idx)};
            for (int i = 1; i <= int'(MUL_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            // The exit stage lines up with mul_z for the operands issued MUL_LAT edges ago.
            rsp_valid <= tag_exit.valid ? (N_REQ'(1) << tag_exit.id) : '0;
            if (tag_exit.valid) begin
                rsp_data <= mul_z;
            end
        end
    end

`ifdef FPMUL_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] issue_cnt_q [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            for (int i = 0; i < int'(N_REQ); i++) begin
                issue_cnt_q[i] <= '0;
            end
        end else begin
            if ((|(req_valid & ~grant)) && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (grant[i] && (issue_cnt_q[i] != '1)) begin
                    issue_cnt_q[i] <= issue_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        perf_issue_cnt = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            perf_issue_cnt[i*PERF_CNT_W +: PERF_CNT_W] = issue_cnt_q[i];
        end
    end
`endif

endmodule
